// File: rtl/stream_width_upsizer.sv
// Packs RATIO consecutive IN_WIDTH beats into one registered wide word.
// An accepted in_last closes the word early; out_keep marks the filled lanes.
module stream_width_upsizer #(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned RATIO    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IN_WIDTH-1:0]         in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [IN_WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [RATIO-1:0][IN_WIDTH-1:0]   word_data_c;
  logic [RATIO-1:0]                 word_keep_c;
  logic [RATIO-1:0][IN_WIDTH-1:0]   out_data_q, out_data_d;
  logic [RATIO-1:0]                 out_keep_q, out_keep_d;
  logic                             out_last_q, out_last_d;
  logic                             out_valid_q, out_valid_d;
  logic                             busy_q, busy_d;
  logic                             accept_c, complete_c;

  // Ready only falls while a finished word is stalled downstream.
  assign in_ready   = ~out_valid_q | out_ready;
  assign accept_c   = in_valid & in_ready;
  assign complete_c = accept_c & (in_last | (cnt_q == LAST_LANE));

  // Per-lane assembly: lanes below cnt come from the buffer, lane cnt from the live beat.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    logic sel_c;
    logic below_c;
    assign sel_c   = (cnt_q == CNT_W'(g));
    assign below_c = (cnt_q >  CNT_W'(g));

    if (g < RATIO - 1) begin : g_buf
      logic [IN_WIDTH-1:0] buf_data_q;
      logic                buf_keep_q;

      assign word_data_c[g] = below_c ? buf_data_q : (sel_c ? in_data : '0);
      assign word_keep_c[g] = (below_c & buf_keep_q) | sel_c;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_data_q <= '0;
          buf_keep_q <= 1'b0;
        end else if (complete_c) begin
          buf_data_q <= '0;
          buf_keep_q <= 1'b0;
        end else if (accept_c && sel_c) begin
          buf_data_q <= in_data;
          buf_keep_q <= 1'b1;
        end
      end
    end else begin : g_top
      // The top lane is only ever filled by a completing beat, so it needs no storage.
      assign word_data_c[g] = sel_c ? in_data : '0;
      assign word_keep_c[g] = sel_c;
    end
  end

  // Next-state: a completing beat loads a new word even while the old one drains.
  always_comb begin
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (complete_c) begin
      cnt_d       = '0;
      out_data_d  = word_data_c;
      out_keep_d  = word_keep_c;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
    end else begin
      if (accept_c) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
    busy_d = (cnt_d != '0) | out_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
